// File: rtl/bkram_sector_ctrl.sv
// Backup-RAM save/load sequencer: streams a 2**SECT_AW sector image through the
// hps_io SD sector port, writes a format header, and aborts stalled requests.
module bkram_sector_ctrl #(
   parameter int unsigned SECT_AW   = 4,
   parameter int unsigned FMT_WORDS = 4,
   parameter logic [FMT_WORDS*16-1:0] FMT_TAB = {16'h5548, 16'h4D42, 16'h8800, 16'h8010},
   parameter int unsigned TIMEOUT   = 2**24
) (
   input  logic                 clk_sys,
   input  logic                 reset_n,
   input  logic                 dl_active,
   input  logic                 img_mounted,
   input  logic                 img_readonly,
   input  logic                 img_nz,
   input  logic                 load_req,
   input  logic                 save_req,
   input  logic                 fmt_req,
   input  logic                 autosave,
   input  logic                 osd_open,
   input  logic                 core_bwr,
   input  logic                 sd_ack,
   output logic [31:0]          sd_lba,
   output logic                 sd_rd,
   output logic                 sd_wr,
   output logic [SECT_AW+7:0]   fmt_addr,
   output logic [15:0]          fmt_data,
   output logic                 fmt_we,
   output logic                 bk_ena,
   output logic                 bk_busy,
   output logic                 bk_loading,
   output logic                 bk_pending,
   output logic                 bk_err
);

   localparam int unsigned FA_W = SECT_AW + 8;
   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
   localparam int unsigned FI_W = (FMT_WORDS > 1) ? $clog2(FMT_WORDS) : 1;
   localparam int unsigned TB_W = FMT_WORDS * 16;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_FMT} state_t;

   // Header word idx; word 0 sits in the most significant slot of FMT_TAB.
   function automatic logic [15:0] tab_word(input logic [FI_W-1:0] idx);
      logic [TB_W-1:0] sh;
      sh = FMT_TAB << (16 * 32'(idx));
      return sh[TB_W-1 -: 16];
   endfunction

   state_t            r_state, w_state;
   logic              r_dir, w_dir;              // 1 = read (load), 0 = write (save)
   logic [SECT_AW-1:0] r_lba, w_lba;
   logic              r_rd, w_rd, r_wr, w_wr;
   logic              r_fmt_q, w_fmt_q;
   logic [FI_W-1:0]   r_fmt_idx, w_fmt_idx;
   logic              r_fmt_we, w_fmt_we;
   logic [FA_W-1:0]   r_fmt_addr, w_fmt_addr;
   logic [15:0]       r_fmt_data, w_fmt_data;
   logic              r_ena, w_ena;
   logic              r_pending, w_pending;
   logic              r_err, w_err;
   logic              r_busy, w_busy;
   logic              r_loading, w_loading;
   logic [WD_W-1:0]   r_wdog, w_wdog;
   logic              r_dl_d, r_load_d, r_save_d, r_fmt_d, r_auto_d, r_ack_d;

   logic w_dl_rise, w_dl_fall, w_auto, w_load_trig, w_save_trig, w_fmt_rise;
   logic w_ack_rise, w_ack_fall;

   assign w_dl_rise   = dl_active & ~r_dl_d;
   assign w_dl_fall   = ~dl_active & r_dl_d;
   assign w_auto      = r_pending & osd_open & autosave;
   assign w_load_trig = (load_req & ~r_load_d) | (w_dl_fall & r_ena & img_nz);
   assign w_save_trig = (save_req & ~r_save_d) | (w_auto & ~r_auto_d);
   assign w_fmt_rise  = fmt_req & ~r_fmt_d;
   assign w_ack_rise  = sd_ack & ~r_ack_d;
   assign w_ack_fall  = ~sd_ack & r_ack_d;

   // State and registered outputs.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_dir      <= 1'b0;
         r_lba      <= '0;
         r_rd       <= 1'b0;
         r_wr       <= 1'b0;
         r_fmt_q    <= 1'b0;
         r_fmt_idx  <= '0;
         r_fmt_we   <= 1'b0;
         r_fmt_addr <= '0;
         r_fmt_data <= '0;
         r_ena      <= 1'b0;
         r_pending  <= 1'b0;
         r_err      <= 1'b0;
         r_busy     <= 1'b0;
         r_loading  <= 1'b0;
         r_wdog     <= '0;
         r_dl_d     <= 1'b0;
         r_load_d   <= 1'b0;
         r_save_d   <= 1'b0;
         r_fmt_d    <= 1'b0;
         r_auto_d   <= 1'b0;
         r_ack_d    <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_dir      <= w_dir;
         r_lba      <= w_lba;
         r_rd       <= w_rd;
         r_wr       <= w_wr;
         r_fmt_q    <= w_fmt_q;
         r_fmt_idx  <= w_fmt_idx;
         r_fmt_we   <= w_fmt_we;
         r_fmt_addr <= w_fmt_addr;
         r_fmt_data <= w_fmt_data;
         r_ena      <= w_ena;
         r_pending  <= w_pending;
         r_err      <= w_err;
         r_busy     <= w_busy;
         r_loading  <= w_loading;
         r_wdog     <= w_wdog;
         r_dl_d     <= dl_active;
         r_load_d   <= load_req;
         r_save_d   <= save_req;
         r_fmt_d    <= fmt_req;
         r_auto_d   <= w_auto;
         r_ack_d    <= sd_ack;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state    = r_state;
      w_dir      = r_dir;
      w_lba      = r_lba;
      w_rd       = 1'b0;
      w_wr       = 1'b0;
      w_fmt_q    = r_fmt_q | w_fmt_rise;
      w_fmt_idx  = r_fmt_idx;
      w_fmt_we   = 1'b0;
      w_fmt_addr = r_fmt_addr;
      w_fmt_data = r_fmt_data;
      w_err      = r_err;
      w_wdog     = '0;

      w_ena = r_ena;
      if (w_dl_rise)
         w_ena = 1'b0;
      if (dl_active & img_mounted & ~img_readonly)
         w_ena = 1'b1;

      unique case (r_state)
         S_IDLE: begin
            if (w_load_trig | w_save_trig) begin
               w_lba = '0;
               w_err = 1'b0;
            end
            if (w_load_trig & r_ena) begin
               w_state = S_REQ;
               w_dir   = 1'b1;
               w_rd    = 1'b1;
            end else if (w_save_trig & r_ena) begin
               w_state = S_REQ;
               w_dir   = 1'b0;
               w_wr    = 1'b1;
            end else if (r_fmt_q) begin
               w_state    = S_FMT;
               w_fmt_idx  = '0;
               w_fmt_we   = 1'b1;
               w_fmt_addr = '0;
               w_fmt_data = tab_word('0);
            end
         end
         S_REQ: begin
            if (w_ack_rise) begin
               w_state = S_XFER;
            end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
               w_state = S_IDLE;
               w_err   = 1'b1;
            end else begin
               w_rd   = r_dir;
               w_wr   = ~r_dir;
               w_wdog = r_wdog + WD_W'(1);
            end
         end
         S_XFER: begin
            if (w_ack_fall) begin
               if (&r_lba) begin
                  w_state = S_IDLE;
               end else begin
                  w_state = S_REQ;
                  w_lba   = r_lba + SECT_AW'(1);
                  w_rd    = r_dir;
                  w_wr    = ~r_dir;
               end
            end
         end
         S_FMT: begin
            if (r_fmt_idx == FI_W'(FMT_WORDS - 1)) begin
               w_state = S_IDLE;
               w_fmt_q = 1'b0;
            end else begin
               w_fmt_idx  = r_fmt_idx + FI_W'(1);
               w_fmt_we   = 1'b1;
               w_fmt_addr = FA_W'(w_fmt_idx);
               w_fmt_data = tab_word(w_fmt_idx);
            end
         end
         default: w_state = S_IDLE;
      endcase

      w_busy    = (w_state == S_REQ) || (w_state == S_XFER);
      w_loading = w_busy & w_dir;

      // A busy cycle always clears pending, even against a same-cycle core write.
      w_pending = r_pending | (r_ena & ~osd_open & core_bwr);
      if (r_busy | w_busy)
         w_pending = 1'b0;
   end

   assign sd_lba     = 32'(r_lba);
   assign sd_rd      = r_rd;
   assign sd_wr      = r_wr;
   assign fmt_addr   = r_fmt_addr;
   assign fmt_data   = r_fmt_data;
   assign fmt_we     = r_fmt_we;
   assign bk_ena     = r_ena;
   assign bk_busy    = r_busy;
   assign bk_loading = r_loading;
   assign bk_pending = r_pending;
   assign bk_err     = r_err;

endmodule

// File: tb/tb_bkram_sector_ctrl.sv
// Directed bench for bkram_sector_ctrl: attach/pending table, then load, save,
// format, busy-drop, watchdog and reset-mid-transfer sequences.
module tb_bkram_sector_ctrl;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        dl_active = 1'b0, img_mounted = 1'b0, img_readonly = 1'b0, img_nz = 1'b0;
   logic        load_req = 1'b0, save_req = 1'b0, fmt_req = 1'b0, autosave = 1'b0;
   logic        osd_open = 1'b0, core_bwr = 1'b0, sd_ack = 1'b0;
   logic [31:0] sd_lba;
   logic        sd_rd, sd_wr, fmt_we;
   logic [11:0] fmt_addr;
   logic [15:0] fmt_data;
   logic        bk_ena, bk_busy, bk_loading, bk_pending, bk_err;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [15:0] TAB [4] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

   typedef struct {
      logic dl, mnt, ro, nz, bwr, osd, aus;
      logic e_ena, e_pend, e_busy;
   } vec_t;
   vec_t vecs [13];

   bkram_sector_ctrl #(.SECT_AW(4), .FMT_WORDS(4), .TIMEOUT(100)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .dl_active(dl_active),
      .img_mounted(img_mounted), .img_readonly(img_readonly), .img_nz(img_nz),
      .load_req(load_req), .save_req(save_req), .fmt_req(fmt_req),
      .autosave(autosave), .osd_open(osd_open), .core_bwr(core_bwr),
      .sd_ack(sd_ack), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
      .fmt_addr(fmt_addr), .fmt_data(fmt_data), .fmt_we(fmt_we),
      .bk_ena(bk_ena), .bk_busy(bk_busy), .bk_loading(bk_loading),
      .bk_pending(bk_pending), .bk_err(bk_err)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // One sector handshake; rd=1 expects sd_rd, rd=0 expects sd_wr.
   task automatic xfer_one(input bit rd, input int s);
      int w;
      w = 0;
      while (!(sd_rd || sd_wr) && w < 50) begin
         tick();
         w++;
      end
      chk("req dir", 32'({sd_rd, sd_wr}), rd ? 32'd2 : 32'd1);
      chk("req lba", sd_lba, 32'(s));
      chk("req loading", 32'(bk_loading), 32'(rd));
      chk("req pending", 32'(bk_pending), 32'd0);
      sd_ack = 1'b1;
      tick();
      chk("req drop", 32'({sd_rd, sd_wr}), 32'd0);
      chk("xfer busy", 32'(bk_busy), 32'd1);
      tick();
      sd_ack = 1'b0;
      tick();
      if (s < 15) begin
         chk("next lba", sd_lba, 32'(s + 1));
         chk("reassert", 32'(sd_rd | sd_wr), 32'd1);
      end else begin
         chk("done busy", 32'({bk_busy, bk_loading}), 32'd0);
         chk("done lba", sd_lba, 32'd15);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout: got running, expected finished");
      $fatal(1);
   end

   initial begin
      int cnt;
      int bad;
      //          dl   mnt  ro   nz   bwr  osd  aus   ena  pend busy
      vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0};
      vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0};
      vecs[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0};
      vecs[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0};
      vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0};
      vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0};
      vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0};
      vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0};
      vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0};
      vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0};
      vecs[10] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0};
      vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0};
      vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0};

      // Reset values
      #12;
      chk("rst lba", sd_lba, 32'd0);
      chk("rst flags", 32'({sd_rd, sd_wr, fmt_we, bk_ena, bk_busy, bk_loading, bk_pending, bk_err}), 32'd0);
      chk("rst fmt", 32'({fmt_addr, fmt_data}), 32'd0);
      reset_n = 1'b1;
      tick();

      // Attach and pending table
      for (int i = 0; i < 13; i++) begin
         dl_active = vecs[i].dl; img_mounted = vecs[i].mnt; img_readonly = vecs[i].ro;
         img_nz = vecs[i].nz; core_bwr = vecs[i].bwr; osd_open = vecs[i].osd;
         autosave = vecs[i].aus;
         tick();
         chk($sformatf("vec%0d ena", i), 32'(bk_ena), 32'(vecs[i].e_ena));
         chk($sformatf("vec%0d pend", i), 32'(bk_pending), 32'(vecs[i].e_pend));
         chk($sformatf("vec%0d busy", i), 32'({bk_busy, sd_rd, sd_wr}), 32'({vecs[i].e_busy, 2'b00}));
      end

      // Load after download with a non-empty image
      dl_active = 1'b1;
      tick();
      chk("dl rise ena", 32'(bk_ena), 32'd0);
      img_mounted = 1'b1;
      tick();
      chk("mount ena", 32'(bk_ena), 32'd1);
      img_mounted = 1'b0; img_nz = 1'b1; dl_active = 1'b0;
      tick();
      chk("load start", 32'({bk_busy, bk_loading}), 32'd3);
      for (int s = 0; s < 16; s++) xfer_one(1'b1, s);
      img_nz = 1'b0;

      // Autosave of pending writes, with two format requests queued mid-save
      osd_open = 1'b0; core_bwr = 1'b1;
      tick();
      chk("pend set", 32'(bk_pending), 32'd1);
      core_bwr = 1'b0; osd_open = 1'b1; autosave = 1'b1;
      tick();
      for (int s = 0; s < 16; s++) begin
         if (s == 5 || s == 7) fmt_req = 1'b1;
         if (s == 6 || s == 8) fmt_req = 1'b0;
         xfer_one(1'b0, s);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("fmt%0d we", k), 32'(fmt_we), 32'd1);
         chk($sformatf("fmt%0d addr", k), 32'(fmt_addr), 32'(k));
         chk($sformatf("fmt%0d data", k), 32'(fmt_data), 32'(TAB[k]));
      end
      tick();
      chk("fmt end", 32'(fmt_we), 32'd0);
      bad = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (fmt_we) bad++;
      end
      chk("fmt once", 32'(bad), 32'd0);

      // Simultaneous load and save: read wins; a save rise while busy is dropped
      load_req = 1'b1; save_req = 1'b1;
      tick();
      for (int s = 0; s < 16; s++) begin
         if (s == 1) begin load_req = 1'b0; save_req = 1'b0; end
         if (s == 3) save_req = 1'b1;
         if (s == 5) save_req = 1'b0;
         xfer_one(1'b1, s);
      end
      bad = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (sd_rd || sd_wr || bk_busy) bad++;
      end
      chk("busy drop", 32'(bad), 32'd0);

      // Watchdog: stall the save at sector 3
      save_req = 1'b1;
      tick();
      save_req = 1'b0;
      for (int s = 0; s < 3; s++) xfer_one(1'b0, s);
      cnt = 0;
      while (sd_wr && cnt < 300) begin
         cnt++;
         tick();
      end
      chk("wdog cycles", 32'(cnt), 32'd100);
      chk("wdog err", 32'(bk_err), 32'd1);
      chk("wdog idle", 32'({bk_busy, sd_rd, sd_wr}), 32'd0);
      chk("wdog lba", sd_lba, 32'd3);

      // Reset in the middle of a save
      save_req = 1'b1;
      tick();
      save_req = 1'b0;
      chk("err clear", 32'(bk_err), 32'd0);
      for (int s = 0; s < 7; s++) xfer_one(1'b0, s);
      reset_n = 1'b0;
      #2;
      chk("arst req", 32'({sd_rd, sd_wr}), 32'd0);
      chk("arst lba", sd_lba, 32'd0);
      chk("arst flags", 32'({bk_ena, bk_busy, bk_pending, bk_err}), 32'd0);
      #2;
      reset_n = 1'b1;
      tick();
      dl_active = 1'b1; img_mounted = 1'b1;
      tick();
      chk("remount ena", 32'(bk_ena), 32'd1);
      dl_active = 1'b0; img_mounted = 1'b0;
      tick();
      chk("remount idle", 32'(bk_busy), 32'd0);
      save_req = 1'b1;
      tick();
      save_req = 1'b0;
      for (int s = 0; s < 16; s++) xfer_one(1'b0, s);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
